seg7_scan_reader: RTL and testbench

- Reads back a multiplexed, active-low 7-segment display bus (digit anodes plus segment lines) and recovers the hex value shown on each digit.
- Used as the display-side monitor/loopback checker for the hex-to-7-segment decode path, and as a front end for capturing the digits shown by external 7-segment sources.
- Each digit's pattern must stay stable for STABLE_CNT consecutive sample strobes before it is committed. This rejects scan ghosting and transition glitches.
- Flags blank digits and illegal patterns.

---
 rtl/seg7_scan_reader.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers per-digit hex values from a multiplexed active-low 7-segment bus
//   clk, reset_n   : clock, async active-low reset
//   sample_en      : sample strobe; inputs are evaluated only when high
//   an, seg        : active-low digit selects and segment lines (seg[0]=a .. seg[6]=g)
//   err_clr        : synchronous clear of err_flags
//   hex_out        : committed value of digit i on bits [4i+3:4i]
//   digit_valid    : digit i last committed as a legal hex code
//   digit_blank    : digit i last committed as all-off
//   err_flags      : sticky per-digit illegal-pattern flags
//   upd, upd_idx   : commit pulse and index of the last committed digit
//   frame_done     : pulse when every digit has committed since the previous pulse
module seg7_scan_reader #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_en,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [0:6]              seg,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   err_flags,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic                    frame_done
);
    typedef enum logic {HUNT, LOCKED} state_t;
    localparam int CW = NUM_DIGITS + 7;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cand_q, cand_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_n;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d, err_q, err_d;
    logic                    upd_q, upd_d, frame_q, frame_d;
    logic [2:0]              idx_q, idx_d, idx;
    logic                    an_legal, commit, is_blank;
    logic [4:0]              dec;
    // {legal, value}; legal=0 for anything outside the 16 hex glyphs
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0001100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction
    assign an_legal = $onehot(~an);
    assign dec      = decode(seg);
    assign is_blank = (seg == 7'h7F);
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an[i]) idx = 3'(i);
    end
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (sample_en) begin
            if (!an_legal) begin
                cnt_d   = 4'd0;
                state_d = HUNT;
            end else if ({an, seg} != cand_q) begin
                cand_d  = {an, seg};
                cnt_d   = 4'd1;
                state_d = HUNT;
                commit  = (STABLE_CNT == 1);
            end else if (state_q == HUNT) begin
                cnt_d  = cnt_q + 4'd1;
                commit = (cnt_d == 4'(STABLE_CNT));
            end
            if (commit) state_d = LOCKED;
        end
    end
    always_comb begin
        hex_d   = hex_q;
        valid_d = valid_q;
        blank_d = blank_q;
        err_d   = err_clr ? '0 : err_q;
        upd_d   = commit;
        idx_d   = commit ? idx : idx_q;
        frame_d = 1'b0;
        seen_n  = seen_q | (commit ? ~an : '0);
        seen_d  = seen_n;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit && !an[i]) begin
                // illegal glyphs leave the previous hex value in place
                hex_d[4*i +: 4] = dec[4] ? dec[3:0] : (is_blank ? 4'h0 : hex_q[4*i +: 4]);
                valid_d[i]      = dec[4];
                blank_d[i]      = is_blank;
                err_d[i]        = err_d[i] | (!dec[4] && !is_blank);
            end
        end
        if (commit && &seen_n) begin
            frame_d = 1'b1;
            seen_d  = '0;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
            cand_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= '0;
            hex_q   <= '0;
            valid_q <= '0;
            blank_q <= '0;
            err_q   <= '0;
            upd_q   <= 1'b0;
            idx_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end
    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign digit_blank = blank_q;
    assign err_flags   = err_q;
    assign upd         = upd_q;
    assign upd_idx     = idx_q;
    assign frame_done  = frame_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed and randomized checks against a run-length reference model
module tb_seg7_scan_reader;
    localparam int N = 4;
    localparam int S = 3;
    logic           clk = 1'b0, reset_n = 1'b0, sample_en = 1'b0, err_clr = 1'b0;
    logic [N-1:0]   an = '1;
    logic [0:6]     seg = 7'h7F;
    logic [4*N-1:0] hex_out;
    logic [N-1:0]   digit_valid, digit_blank, err_flags;
    logic           upd, frame_done;
    logic [2:0]     upd_idx;
    int checks = 0, errors = 0;
    seg7_scan_reader #(.NUM_DIGITS(N), .STABLE_CNT(S)) dut (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .an(an), .seg(seg),
        .err_clr(err_clr), .hex_out(hex_out), .digit_valid(digit_valid),
        .digit_blank(digit_blank), .err_flags(err_flags), .upd(upd),
        .upd_idx(upd_idx), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    // reference model: a digit commits when the same legal sample has been seen S times in a row
    logic [4*N-1:0] m_hex;
    logic [N-1:0]   m_valid, m_blank, m_err, m_seen;
    logic           m_upd, m_frame;
    logic [2:0]     m_idx;
    logic [N+6:0]   last;
    int             run;
    task automatic model_reset();
        m_hex = '0; m_valid = '0; m_blank = '0; m_err = '0; m_seen = '0;
        m_upd = 0; m_frame = 0; m_idx = '0; last = '0; run = 0;
    endtask
    task automatic model_edge();
        int k;
        logic hit;
        logic [3:0] v;
        m_upd = 0;
        m_frame = 0;
        if (err_clr) m_err = '0;
        if (!sample_en) return;
        if ($countones(an) != N - 1) begin
            run = 0;
            return;
        end
        if (run > 0 && {an, seg} == last) run++;
        else begin
            last = {an, seg};
            run = 1;
        end
        if (run != S) return;
        k = 0;
        for (int i = 0; i < N; i++) if (!an[i]) k = i;
        hit = 0;
        v = 0;
        for (int c = 0; c < 16; c++) if (seg == tbl[c]) begin hit = 1; v = c[3:0]; end
        if (hit) begin
            m_hex[4*k +: 4] = v; m_valid[k] = 1; m_blank[k] = 0;
        end else if (seg == 7'h7F) begin
            m_hex[4*k +: 4] = 4'h0; m_valid[k] = 0; m_blank[k] = 1;
        end else begin
            m_valid[k] = 0; m_blank[k] = 0; m_err[k] = 1;
        end
        m_upd = 1;
        m_idx = k[2:0];
        m_seen[k] = 1;
        if (&m_seen) begin
            m_frame = 1;
            m_seen = '0;
        end
    endtask
    function automatic logic [7*N+4:0] exp_vec();
        return {m_hex, m_valid, m_blank, m_err, m_upd, m_idx, m_frame};
    endfunction
    function automatic logic [7*N+4:0] obs();
        return {hex_out, digit_valid, digit_blank, err_flags, upd, upd_idx, frame_done};
    endfunction
    task automatic cyc(input logic se, input logic [N-1:0] a, input logic [6:0] s, input logic ec);
        @(negedge clk);
        sample_en = se; an = a; seg = s; err_clr = ec;
        @(posedge clk);
        model_edge();
        #1;
        sample_en = 0; err_clr = 0;
    endtask
    task automatic assert_reset();
        @(negedge clk);
        #2 reset_n = 0;
        sample_en = 0; err_clr = 0;
        model_reset();
        #1;
    endtask
    task automatic release_reset();
        @(negedge clk);
        reset_n = 1;
    endtask
    task automatic test_reset();
        assert_reset();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_zero: got %h exp 0", obs()); end
        release_reset();
        cyc(0, '1, 7'h7F, 0);
        checks++;
        if (obs() !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h exp %h", obs(), exp_vec()); end
    endtask
    task automatic test_commit();
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 4'b1110, 7'b0000110, 0);
            checks++;
            if (obs() !== exp_vec()) begin errors++; $display("FAIL commit_%0d: got %h exp %h", i, obs(), exp_vec()); end
            checks++;
            if (upd !== (i == 3)) begin errors++; $display("FAIL commit_upd_%0d: got %b exp %b", i, upd, i == 3); end
            if (i == 3) begin
                checks++;
                if ({hex_out[3:0], digit_valid, upd_idx} !== {4'h3, 4'b0001, 3'd0})
                    begin errors++; $display("FAIL commit_val: got %h %b %0d exp 3 0001 0", hex_out[3:0], digit_valid, upd_idx); end
                cyc(0, 4'b1110, 7'b0000110, 0);
                checks++;
                if (upd !== 1'b0) begin errors++; $display("FAIL commit_pulse: got %b exp 0", upd); end
            end
        end
    endtask
    task automatic test_glitch();
        logic [6:0] pat [6] = '{7'b0001000, 7'b0001000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
        for (int i = 0; i < 6; i++) begin
            cyc(1, 4'b1101, pat[i], 0);
            checks++;
            if (obs() !== exp_vec()) begin errors++; $display("FAIL glitch_%0d: got %h exp %h", i, obs(), exp_vec()); end
            checks++;
            if (upd !== (i == 4)) begin errors++; $display("FAIL glitch_upd_%0d: got %b exp %b", i, upd, i == 4); end
        end
        checks++;
        if (hex_out[7:4] !== 4'h8) begin errors++; $display("FAIL glitch_val: got %h exp 8", hex_out[7:4]); end
    endtask
    task automatic test_error();
        logic [3:0] prior;
        prior = m_hex[11:8];
        for (int i = 0; i < 3; i++) cyc(1, 4'b1011, 7'b1111110, 0);
        checks++;
        if ({err_flags, digit_valid[2], hex_out[11:8]} !== {4'b0100, 1'b0, prior})
            begin errors++; $display("FAIL err_set: got %b %b %h exp 0100 0 %h", err_flags, digit_valid[2], hex_out[11:8], prior); end
        cyc(0, 4'b1011, 7'b1111110, 1);
        checks++;
        if (err_flags !== 4'b0000) begin errors++; $display("FAIL err_clr: got %b exp 0000", err_flags); end
        cyc(1, 4'b1111, 7'h7F, 0);
        for (int i = 0; i < 3; i++) cyc(1, 4'b1011, 7'b1111110, i == 2);
        checks++;
        if (err_flags !== 4'b0100) begin errors++; $display("FAIL err_set_wins: got %b exp 0100", err_flags); end
        checks++;
        if (obs() !== exp_vec()) begin errors++; $display("FAIL err_model: got %h exp %h", obs(), exp_vec()); end
    endtask
    task automatic test_blank_illegal_an();
        logic [N-1:0] as [6] = '{4'b0111, 4'b0111, 4'b1100, 4'b0111, 4'b0111, 4'b0111};
        for (int i = 0; i < 3; i++) cyc(1, 4'b0111, 7'h7F, 0);
        checks++;
        if ({digit_blank, hex_out[15:12]} !== {4'b1000, 4'h0})
            begin errors++; $display("FAIL blank: got %b %h exp 1000 0", digit_blank, hex_out[15:12]); end
        for (int i = 0; i < 6; i++) begin
            cyc(1, as[i], tbl[5], 0);
            checks++;
            if (obs() !== exp_vec()) begin errors++; $display("FAIL bad_an_%0d: got %h exp %h", i, obs(), exp_vec()); end
            checks++;
            if (upd !== (i == 5)) begin errors++; $display("FAIL bad_an_upd_%0d: got %b exp %b", i, upd, i == 5); end
        end
    endtask
    task automatic test_scan_rotation();
        int frames;
        logic [3:0] vals [4] = '{4'h1, 4'h2, 4'hC, 4'hF};
        frames = 0;
        assert_reset();
        release_reset();
        for (int d = 0; d < N; d++)
            for (int r = 0; r < 3; r++) begin
                cyc(1, ~(N'(1) << d), tbl[vals[d]], 0);
                checks++;
                if (obs() !== exp_vec()) begin errors++; $display("FAIL scan_%0d_%0d: got %h exp %h", d, r, obs(), exp_vec()); end
                if (frame_done) begin
                    frames++;
                    checks++;
                    if ({upd, upd_idx} !== {1'b1, 3'd3}) begin errors++; $display("FAIL scan_frame_idx: got %b %0d exp 1 3", upd, upd_idx); end
                end
            end
        cyc(0, '1, 7'h7F, 0);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL scan_frame_pulse: got %b exp 0", frame_done); end
        checks++;
        if ({hex_out, frames} !== {16'hFC21, 32'd1}) begin errors++; $display("FAIL scan_total: got %h frames %0d exp fc21 1", hex_out, frames); end
    endtask
    task automatic test_reset_mid();
        cyc(1, 4'b1101, tbl[9], 0);
        cyc(1, 4'b1101, tbl[9], 0);
        assert_reset();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL rmid_zero: got %h exp 0", obs()); end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'b1101, tbl[9], 0);
            checks++;
            if (upd !== (i == 2)) begin errors++; $display("FAIL rmid_upd_%0d: got %b exp %b", i, upd, i == 2); end
            checks++;
            if (obs() !== exp_vec()) begin errors++; $display("FAIL rmid_%0d: got %h exp %h", i, obs(), exp_vec()); end
        end
    endtask
    task automatic test_random();
        for (int it = 0; it < 250; it++) begin
            logic [N-1:0] a;
            logic [6:0] s;
            int reps;
            a = ($urandom_range(0, 9) < 8) ? ~(N'(1) << $urandom_range(0, N-1)) : N'($urandom);
            s = ($urandom_range(0, 9) < 7) ? tbl[$urandom_range(0, 15)] : ($urandom_range(0, 1) ? 7'h7F : 7'($urandom));
            reps = $urandom_range(1, 5);
            for (int r = 0; r < reps; r++) begin
                cyc($urandom_range(0, 4) != 0, a, s, $urandom_range(0, 19) == 0);
                checks++;
                if (obs() !== exp_vec()) begin errors++; $display("FAIL rand_%0d: got %h exp %h", it, obs(), exp_vec()); end
            end
        end
    endtask
    initial begin
        model_reset();
        test_reset();
        test_commit();
        test_glitch();
        test_error();
        test_blank_illegal_an();
        test_scan_rotation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
